// File: rtl/icache_pkg.sv
// Shared widths, FSM state type and address-field helpers for the
// instruction-cache fill controller.
package icache_pkg;

    localparam int TAG_W      = 24;
    localparam int IDX_W      = 3;
    localparam int OFF_W      = 5;
    localparam int LINE_W     = 256;
    localparam int NUM_LINES  = 8;
    localparam int WORD_SEL_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31:IDX_W+OFF_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
        return addr[IDX_W+OFF_W-1:OFF_W];
    endfunction

    // Word within the 256-bit line; the two byte-offset bits are ignored.
    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [31:0] addr);
        return addr[OFF_W-1:2];
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:OFF_W], {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_fill_controller_if.sv
// CPU-side fetch handshake and pmem-side line-fill handshake.
// master = fetch stage / memory arbiter, slave = fill controller.
interface icache_fill_controller_if;
    import icache_pkg::*;

    logic              cpu_read;
    logic [31:0]       cpu_address;
    logic [31:0]       cpu_rdata;
    logic              cpu_resp;

    logic              pmem_read;
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        output cpu_read,
        output cpu_address,
        input  cpu_rdata,
        input  cpu_resp,
        input  pmem_read,
        input  pmem_address,
        output pmem_rdata,
        output pmem_resp
    );

    modport slave (
        input  cpu_read,
        input  cpu_address,
        output cpu_rdata,
        output cpu_resp,
        output pmem_read,
        output pmem_address,
        input  pmem_rdata,
        input  pmem_resp
    );

endinterface

// File: rtl/icache_tag_array.sv
// Direct-mapped tag + valid store: one write port, combinational read,
// single-cycle clear of every valid bit.
module icache_tag_array #(
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [2:0]       windex,
    input  logic [TAG_W-1:0] wtag,
    input  logic             clear_all,
    input  logic [2:0]       rindex,
    output logic [TAG_W-1:0] rtag,
    output logic             rvalid
);
    import icache_pkg::*;

    logic [TAG_W-1:0]     tag_r [NUM_LINES];
    logic [NUM_LINES-1:0] valid_r;

    // Valid bits; a clear on the same edge as a write wins, so a line
    // filled while a flush is pending does not survive the flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else if (clear_all) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else if (we) begin
            valid_r[windex] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_r[i] <= {TAG_W{1'b0}};
            end
        end else if (we) begin
            tag_r[windex] <= wtag;
        end else begin
            tag_r[windex] <= tag_r[windex];
        end
    end

    assign rtag   = tag_r[rindex];
    assign rvalid = valid_r[rindex];

endmodule

// File: rtl/icache_fill_controller.sv
// Hit/miss sequencer for an 8-line direct-mapped instruction cache: tag
// lookup, line fill over pmem, word select, flush handling and counters.
module icache_fill_controller #(
    parameter int TAG_W = 24,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    icache_fill_controller_if.slave   bus,
    input  logic                      flush,
    output logic                      da_load,
    output logic [2:0]                da_rindex,
    output logic [2:0]                da_windex,
    output logic [255:0]              da_datain,
    input  logic [255:0]              da_dataout,
    output logic [CNT_W-1:0]          hit_count,
    output logic [CNT_W-1:0]          miss_count
);
    import icache_pkg::*;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    icache_state_t    state_r;
    icache_state_t    state_next_s;
    logic             flush_pend_r;
    logic [31:0]      paddr_r;
    logic [CNT_W-1:0] hit_cnt_r;
    logic [CNT_W-1:0] miss_cnt_r;

    logic             resp_s;
    logic             load_s;
    logic             clear_s;
    logic             tag_we_s;
    logic             hit_s;
    logic             miss_s;
    logic             lookup_hit_s;
    logic [TAG_W-1:0] rtag_s;
    logic             rvalid_s;
    logic [2:0]       word_s;

    icache_tag_array #(.TAG_W(TAG_W)) u_tags (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (tag_we_s),
        .windex    (addr_index(paddr_r)),
        .wtag      (paddr_r[31:8]),
        .clear_all (clear_s),
        .rindex    (addr_index(bus.cpu_address)),
        .rtag      (rtag_s),
        .rvalid    (rvalid_s)
    );

    assign lookup_hit_s = rvalid_s && (rtag_s == bus.cpu_address[31:8]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and per-cycle strobes; a flush in IDLE forces the
    // concurrent request to miss since its line is being invalidated.
    always_comb begin
        state_next_s = state_r;
        resp_s       = 1'b0;
        load_s       = 1'b0;
        clear_s      = 1'b0;
        tag_we_s     = 1'b0;
        hit_s        = 1'b0;
        miss_s       = 1'b0;
        case (state_r)
            IDLE: begin
                clear_s = flush;
                if (bus.cpu_read) begin
                    if (lookup_hit_s && !flush) begin
                        hit_s  = 1'b1;
                        resp_s = 1'b1;
                    end else begin
                        miss_s       = 1'b1;
                        state_next_s = FILL;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL: begin
                if (bus.pmem_resp) begin
                    load_s       = 1'b1;
                    tag_we_s     = 1'b1;
                    resp_s       = 1'b1;
                    clear_s      = flush_pend_r | flush;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = FILL;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Flush seen during a fill is held until the fill's write edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend_r <= 1'b0;
        end else if ((state_r == FILL) && bus.pmem_resp) begin
            flush_pend_r <= 1'b0;
        end else if ((state_r == FILL) && flush) begin
            flush_pend_r <= 1'b1;
        end else begin
            flush_pend_r <= flush_pend_r;
        end
    end

    // Line address latched at miss detection, held through the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paddr_r <= 32'h0000_0000;
        end else if (miss_s) begin
            paddr_r <= line_base(bus.cpu_address);
        end else begin
            paddr_r <= paddr_r;
        end
    end

    // Saturating performance counters; unaffected by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_r  <= {CNT_W{1'b0}};
            miss_cnt_r <= {CNT_W{1'b0}};
        end else begin
            hit_cnt_r  <= hit_s  ? sat_inc(hit_cnt_r)  : hit_cnt_r;
            miss_cnt_r <= miss_s ? sat_inc(miss_cnt_r) : miss_cnt_r;
        end
    end

    assign word_s           = addr_word(bus.cpu_address);
    assign bus.cpu_rdata    = da_dataout[{word_s, 5'b00000} +: 32];
    assign bus.cpu_resp     = resp_s;
    assign bus.pmem_read    = (state_r == FILL);
    assign bus.pmem_address = paddr_r;

    assign da_load    = load_s;
    assign da_rindex  = addr_index(bus.cpu_address);
    assign da_windex  = addr_index(paddr_r);
    assign da_datain  = bus.pmem_rdata;
    assign hit_count  = hit_cnt_r;
    assign miss_count = miss_cnt_r;

endmodule

// File: tb/tb_icache_fill_controller.sv
// Randomized bench for icache_fill_controller with a line-level reference
// cache model and a behavioural data array with write bypass.
module tb_icache_fill_controller;

    // Narrow counters so saturation is reachable in a short run.
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               da_load;
    logic [2:0]         da_rindex;
    logic [2:0]         da_windex;
    logic [255:0]       da_datain;
    logic [255:0]       da_dataout;
    logic [CNT_W-1:0]   hit_count;
    logic [CNT_W-1:0]   miss_count;

    icache_fill_controller_if bus();

    icache_fill_controller #(.TAG_W(24), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush      (flush),
        .da_load    (da_load),
        .da_rindex  (da_rindex),
        .da_windex  (da_windex),
        .da_datain  (da_datain),
        .da_dataout (da_dataout),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External data array: registered write, combinational read with bypass.
    logic [255:0] da_mem [8];
    always_ff @(posedge clk) begin
        if (da_load) da_mem[da_windex] <= da_datain;
    end
    assign da_dataout = (da_load && (da_rindex == da_windex)) ? da_datain : da_mem[da_rindex];

    // Reference model state.
    bit           m_valid [8];
    logic [23:0]  m_tag   [8];
    logic [255:0] m_line  [8];
    int           m_hits;
    int           m_misses;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_flush();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_reset();
        model_flush();
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int j = 0; j < 8; j++) l[j*32 +: 32] = $urandom;
        return l;
    endfunction

    // One fetch: flush_req pulses flush in the request cycle, flush_fill
    // pulses it in a random cycle of the fill, lat is the pmem wait count.
    task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                           input bit flush_req, input bit flush_fill, input int lat);
        logic [2:0]  idx;
        logic [23:0] tg;
        int          w;
        int          fk;
        bit          hit;
        idx = addr[7:5];
        tg  = addr[31:8];
        w   = int'(addr[4:2]);
        bus.cpu_read    = 1'b1;
        bus.cpu_address = addr;
        flush           = flush_req;
        @(negedge clk);
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
        check("pmem_read_idle", bus.pmem_read, 1'b0);
        hit = m_valid[idx] && (m_tag[idx] == tg) && !flush_req;
        check("resp_req_cycle", bus.cpu_resp, hit);
        if (hit) begin
            check("hit_rdata", bus.cpu_rdata, m_line[idx][w*32 +: 32]);
            m_hits = sat(m_hits);
            next_cycle();
        end else begin
            check("miss_da_load", da_load, 1'b0);
            m_misses = sat(m_misses);
            if (flush_req) model_flush();
            next_cycle();
            flush = 1'b0;
            fk = $urandom_range(0, lat);
            for (int k = 0; k <= lat; k++) begin
                if (k == lat) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = line;
                end
                if (flush_fill && (k == fk)) flush = 1'b1;
                @(negedge clk);
                check("pmem_read_fill", bus.pmem_read, 1'b1);
                check("pmem_address", bus.pmem_address, {addr[31:5], 5'b00000});
                if (k < lat) begin
                    check("resp_wait", bus.cpu_resp, 1'b0);
                    check("da_load_wait", da_load, 1'b0);
                end else begin
                    check("resp_fill", bus.cpu_resp, 1'b1);
                    check("fill_rdata", bus.cpu_rdata, line[w*32 +: 32]);
                    check("da_load_fill", da_load, 1'b1);
                    check("da_windex", da_windex, idx);
                end
                next_cycle();
                flush         = 1'b0;
                bus.pmem_resp = 1'b0;
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_line[idx]  = line;
            if (flush_fill) model_flush();
        end
        bus.cpu_read = 1'b0;
    endtask

    task automatic idle_cycle(input bit do_flush);
        flush = do_flush;
        @(negedge clk);
        check("idle_resp", bus.cpu_resp, 1'b0);
        check("idle_pmem_read", bus.pmem_read, 1'b0);
        check("idle_da_load", da_load, 1'b0);
        if (do_flush) model_flush();
        next_cycle();
        flush = 1'b0;
    endtask

    logic [23:0]  tag_pool [3];
    logic [255:0] tp_line;
    logic [31:0]  a;

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        tag_pool[0]     = 24'h000000;
        tag_pool[1]     = 24'h000001;
        tag_pool[2]     = 24'hABCDE1;
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.cpu_read    = 1'b0;
        bus.cpu_address = 32'h0000_0000;
        bus.pmem_resp   = 1'b0;
        bus.pmem_rdata  = 256'd0;
        model_reset();
        #12;
        check("rst_resp", bus.cpu_resp, 1'b0);
        check("rst_pmem_read", bus.pmem_read, 1'b0);
        check("rst_da_load", da_load, 1'b0);
        check("rst_pmem_address", bus.pmem_address, 32'h0000_0000);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Cold miss, then hit on word 1 of the same line.
        tp_line = rand_line();
        tp_line[31:0]  = 32'hDEADBEEF;
        tp_line[63:32] = 32'h1234_5678;
        do_read(32'h0000_0040, tp_line, 1'b0, 1'b0, 2);
        check("tp_miss_count", miss_count, 1);
        do_read(32'h0000_0044, 256'd0, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("tp_hit_count", hit_count, 1);
        check("tp_no_pmem_read", bus.pmem_read, 1'b0);
        next_cycle();

        // Conflict on index 2 replaces the tag.
        do_read(32'h0000_0140, rand_line(), 1'b0, 1'b0, 1);
        do_read(32'h0000_0040, rand_line(), 1'b0, 1'b0, 0);
        check("tp_conflict_misses", miss_count, 3);

        // Flush during fill, then the same address misses again.
        do_read(32'h0000_0080, rand_line(), 1'b0, 1'b1, 3);
        do_read(32'h0000_0080, rand_line(), 1'b0, 1'b0, 1);
        check("tp_flush_misses", miss_count, 5);
        do_read(32'h0000_0084, 256'd0, 1'b0, 1'b0, 0);
        // Flush with a concurrent request that would otherwise hit.
        do_read(32'h0000_0088, rand_line(), 1'b1, 1'b0, 0);

        // Reset asserted mid-fill.
        bus.cpu_read    = 1'b1;
        bus.cpu_address = 32'h0000_1000;
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_fill_pmem_read", bus.pmem_read, 1'b0);
        check("rst_fill_resp", bus.cpu_resp, 1'b0);
        check("rst_fill_da_load", da_load, 1'b0);
        bus.cpu_read = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        check("post_rst_hit_count", hit_count, 0);
        check("post_rst_miss_count", miss_count, 0);
        do_read(32'h0000_0040, rand_line(), 1'b0, 1'b0, 0);
        do_read(32'h0000_0088, rand_line(), 1'b0, 1'b0, 1);

        // Randomized traffic over a small tag pool to mix hits and misses.
        for (int t = 0; t < 300; t++) begin
            a = {tag_pool[$urandom_range(0, 2)], 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            do_read(a, rand_line(), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) idle_cycle($urandom_range(0, 3) == 0);
        end

        // Drive both counters into saturation.
        for (int t = 0; t < CNT_MAX + 5; t++) begin
            a = {tag_pool[t % 2], 3'd5, 5'd0};
            do_read(a, rand_line(), 1'b0, 1'b0, 0);
        end
        check("miss_saturated", miss_count, CNT_MAX);
        for (int t = 0; t < CNT_MAX + 5; t++) begin
            do_read(32'h0000_01A4, 256'd0, 1'b0, 1'b0, 0);
        end
        idle_cycle(1'b1);
        check("hit_saturated", hit_count, CNT_MAX);
        check("miss_sat_after_flush", miss_count, CNT_MAX);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache_fill_controller.md
# icache_fill_controller

Sequencing controller for the instruction cache's 8-entry, 256-bit-line data array. Direct-mapped. Owns the tag and valid state and the hit/miss state machine. Drives the data array's read and write ports, and fetches missing lines from physical memory over a line-wide handshake. Sits between the fetch stage (CPU side) and the memory arbiter (pmem side).

## Interface
Parameters:
- TAG_W, 24, tag width (32-bit address = 24 tag + 3 index + 5 offset)
- CNT_W, 16, width of the hit and miss performance counters

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_read  in  1  fetch request; held with a stable cpu_address until cpu_resp
- cpu_address  in  32  byte address; bits [1:0] ignored
- cpu_rdata  out  32  selected instruction word, valid while cpu_resp=1
- cpu_resp  out  1  one-cycle completion pulse
- flush  in  1  single-cycle pulse; invalidates all lines
- pmem_read  out  1  line fetch request, held until pmem_resp
- pmem_address  out  32  {tag, index, 5'b0}
- pmem_rdata  in  256  returned line, valid with pmem_resp
- pmem_resp  in  1  one-cycle completion pulse
- da_load  out  1  data array write enable
- da_rindex  out  3  data array read index (= cpu_address[7:5])
- da_windex  out  3  data array write index
- da_datain  out  256  data array write data (= pmem_rdata)
- da_dataout  in  256  data array read data; combinational, forwards da_datain when load and rindex==windex
- hit_count, miss_count  out  CNT_W  saturating performance counters

## Operation
- States: IDLE, FILL.
- IDLE, cpu_read=1:
  - Hit (valid[index] && tag[index]==addr[31:8]): cpu_resp=1 in the same cycle; hit_count increments; stay in IDLE.
  - Miss: no cpu_resp; miss_count increments; latch the line address; go to FILL.
- FILL: pmem_read=1 with the latched pmem_address. On pmem_resp:
  - da_load=1 and da_windex=index.
  - Write tag[index] and set valid[index].
  - cpu_resp=1 with data forwarded through the array's bypass.
  - Return to IDLE.
- cpu_rdata = line word selected by cpu_address[4:2]: word 0 is bits [31:0], word 7 is bits [255:224]. The line is da_dataout.
- Flush:
  - In IDLE: all valid bits clear on the next edge. A cpu_read in the same cycle is forced to a miss.
  - In FILL: flush sets a pending flag. The fill completes and responds normally; all valid bits, including the just-filled line, clear on the edge after pmem_resp.
  - A flush arriving while pending is already set is absorbed.
- Counters saturate at all-ones and do not wrap. They are not cleared by flush.
- da_load=0 in every cycle except the pmem_resp cycle in FILL.

## Timing
- Reset values (async, rst_n=0):
  - State is IDLE; valid, tags, counters and pending flush are all 0.
  - cpu_resp=0, pmem_read=0, da_load=0, pmem_address=0.
  - Reset mid-FILL drops pmem_read immediately. No write or response occurs.
- Hit latency: 0 cycles; cpu_resp is in the request cycle.
- Miss latency: request cycle C (miss detected) → pmem_read high from C+1 → cpu_resp in the pmem_resp cycle. The total is N+1 cycles for a memory latency of N.
- cpu_resp is a single-cycle pulse. A new request may be presented the cycle after cpu_resp.
- pmem_read and pmem_address are stable from FILL entry until pmem_resp. pmem_read deasserts the cycle after pmem_resp.
- Back-to-back accesses to the same index after a fill hit with zero latency.

## Structure
- Package icache_pkg:
  - Widths: TAG_W, index width 3, offset width 5, line width 256.
  - icache_state_t enum {IDLE, FILL}.
  - Address-field extraction functions for tag, index and word select.
- Sub-module icache_tag_array: 8 entries of tag plus valid. One write port. Single-cycle clear-all input. Combinational read. Asynchronous active-low reset.
- The controller FSM, word mux, flush-pending logic and counters live in icache_fill_controller.

## Test plan
- Cold read of 0x0000_0040 → miss_count=1. pmem_read with pmem_address=0x0000_0040. After pmem_resp (line word 0 = 0xDEADBEEF), cpu_resp in the same cycle with cpu_rdata=0xDEADBEEF.
- Repeat read of 0x0000_0044 → hit. cpu_resp in the request cycle with line word 1. hit_count=1. No pmem_read.
- Read 0x0000_0140 (same index 2, different tag) → miss, refill, tag replaced. A following read of 0x0000_0040 misses again.
- Flush pulsed during FILL → the fill response is still correct. The next read of the same address misses.
- Deassert rst_n while in FILL → pmem_read=0 and cpu_resp=0 immediately. After reset, every address misses and the counters read 0.
- Force miss_count to all-ones, then issue a miss → miss_count stays at 0xFFFF.
